// File: rtl/display_lector.sv
// Purpose: observes a multiplexed 8-digit 7-segment display bus and recovers the shown hex digits.
// Latency: a pattern first seen in cycle N is captured, with outputs updated, in cycle N+ESTABLE.
// Backpressure: none; this is a passive monitor and it samples the display bus every cycle.
//
// Ports:
//   clk, reset       single clock; synchronous active-high reset
//   AN[7:0]          digit anodes, active-low; exactly one low bit selects the digit
//   Segmentos[7:0]   segments a..g on bits 7..1, dp on bit 0, all active-low
//   Digitos[31:0]    decoded nibble per digit, digit i at [4i+3:4i]
//   Validos[7:0]     per-digit flag: the nibble holds a valid decode
//   Nuevo / Error    one-cycle pulse per good / undecodable capture
//   Puntos[7:0]      decimal point per digit, present only when DP_CAPTURE_EN is defined
module display_lector #(
  parameter int ESTABLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  AN,
  input  logic [7:0]  Segmentos,
  output logic [31:0] Digitos,
  output logic [7:0]  Validos,
  output logic        Nuevo,
  output logic        Error
`ifdef DP_CAPTURE_EN
  ,
  output logic [7:0]  Puntos
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ESPERA    = 2'd1;
  localparam logic [1:0] CAPTURADO = 2'd2;

  localparam logic [7:0] EST = 8'(ESTABLE);

  // Active-low segment patterns for 0..F. Only bits [7:1] are compared; dp is ignored.
  localparam logic [7:0] TABLA [0:15] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  logic [1:0]  estado, est_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [14:0] clave, clave_ant;
  logic [7:0]  anl;
  logic        califica;
  logic        captura;
  logic [2:0]  idx;
  logic        hit;
  logic [3:0]  nib;

  // Exactly one anode low: the inverted bus is a non-zero power of two.
  assign anl      = ~AN;
  assign califica = (anl != 8'd0) && ((anl & (anl - 8'd1)) == 8'd0);
  assign clave    = {AN, Segmentos[7:1]};

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!AN[i]) idx = 3'(i);
    end
  end

  always_comb begin
    hit = 1'b0;
    nib = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (Segmentos[7:1] == TABLA[i][7:1]) begin
        hit = 1'b1;
        nib = 4'(i);
      end
    end
  end

  always_comb begin
    est_nxt = estado;
    cnt_nxt = cnt;
    captura = 1'b0;
    if (!califica) begin
      est_nxt = IDLE;
      cnt_nxt = 8'd0;
    end else begin
      case (estado)
        IDLE: begin
          est_nxt = ESPERA;
          cnt_nxt = 8'd1;
        end
        ESPERA: begin
          est_nxt = ESPERA;
          if (clave == clave_ant) cnt_nxt = (cnt == EST) ? cnt : cnt + 8'd1;
          else                    cnt_nxt = 8'd1;
        end
        CAPTURADO: begin
          if (clave != clave_ant) begin
            est_nxt = ESPERA;
            cnt_nxt = 8'd1;
          end
        end
        default: begin
          est_nxt = IDLE;
          cnt_nxt = 8'd0;
        end
      endcase
      // Capture happens on the same edge the count reaches ESTABLE, which also
      // covers ESTABLE=1 where the freshly loaded count already qualifies.
      if (est_nxt == ESPERA && cnt_nxt == EST) begin
        captura = 1'b1;
        est_nxt = CAPTURADO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= IDLE;
      cnt       <= 8'd0;
      clave_ant <= '0;
      Digitos   <= '0;
      Validos   <= '0;
      Nuevo     <= 1'b0;
      Error     <= 1'b0;
`ifdef DP_CAPTURE_EN
      Puntos    <= '0;
`endif
    end else begin
      estado    <= est_nxt;
      cnt       <= cnt_nxt;
      clave_ant <= clave;
      Nuevo     <= 1'b0;
      Error     <= 1'b0;
      if (captura) begin
        if (hit) begin
          Digitos[{idx, 2'b00} +: 4] <= nib;
          Validos[idx]               <= 1'b1;
          Nuevo                      <= 1'b1;
`ifdef DP_CAPTURE_EN
          Puntos[idx]                <= ~Segmentos[0];
`endif
        end else begin
          Validos[idx] <= 1'b0;
          Error        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_lector.sv
// Purpose: directed self-checking bench for display_lector with ESTABLE=4.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives the display bus every cycle.
module tb_display_lector;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  AN;
  logic [7:0]  Segmentos;
  logic [31:0] Digitos;
  logic [7:0]  Validos;
  logic        Nuevo;
  logic        Error;
`ifdef DP_CAPTURE_EN
  logic [7:0]  Puntos;
`endif

  int vectores = 0;
  int fallos   = 0;
  int pulsos;

  always #5 clk = ~clk;

  display_lector #(.ESTABLE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .AN        (AN),
    .Segmentos (Segmentos),
    .Digitos   (Digitos),
    .Validos   (Validos),
    .Nuevo     (Nuevo),
    .Error     (Error)
`ifdef DP_CAPTURE_EN
    ,
    .Puntos    (Puntos)
`endif
  );

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectores++;
    if (obs !== exp) begin
      fallos++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of display bus, then sample just after the edge.
  task automatic ciclo(input logic [7:0] an, input logic [7:0] seg);
    AN        = an;
    Segmentos = seg;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] scan_an  [0:7] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] scan_seg [0:7] = '{8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h19, 8'h01};

  initial begin
    // Reset for two cycles.
    reset = 1'b1;
    ciclo(8'hFF, 8'hFF);
    ciclo(8'hFF, 8'hFF);
    chequear("rst_digitos", Digitos, 32'h0);
    chequear("rst_validos", {24'h0, Validos}, 32'h0);
    chequear("rst_nuevo", {31'h0, Nuevo}, 32'h0);
    chequear("rst_error", {31'h0, Error}, 32'h0);
    reset = 1'b0;

    // Digit 0 shows "2" for 10 cycles: one pulse in cycle 4 only.
    for (int i = 1; i <= 10; i++) begin
      ciclo(8'hFE, 8'h25);
      chequear("hold_nuevo", {31'h0, Nuevo}, {31'h0, (i == 4)});
      if (i == 4) begin
        chequear("hold_dig0", {28'h0, Digitos[3:0]}, 32'h2);
        chequear("hold_validos", {24'h0, Validos}, 32'h01);
      end
    end

    // Glitch: 3 cycles then blank, never captured.
    for (int i = 0; i < 3; i++) begin
      ciclo(8'hFD, 8'h61);
      chequear("glitch_nuevo", {31'h0, Nuevo}, 32'h0);
    end
    ciclo(8'hFF, 8'h61);
    chequear("glitch_nuevo_blank", {31'h0, Nuevo}, 32'h0);
    ciclo(8'hFF, 8'h61);
    chequear("glitch_validos", {24'h0, Validos}, 32'h01);

    // Valid "3" on digit 2, then an undecodable pattern on it.
    for (int i = 1; i <= 5; i++) ciclo(8'hFB, 8'h0D);
    chequear("d2_dig", {28'h0, Digitos[11:8]}, 32'h3);
    chequear("d2_validos", {24'h0, Validos}, 32'h05);
    for (int i = 1; i <= 6; i++) begin
      ciclo(8'hFB, 8'hFF);
      chequear("bad_error", {31'h0, Error}, {31'h0, (i == 4)});
      chequear("bad_nuevo", {31'h0, Nuevo}, 32'h0);
    end
    chequear("bad_validos", {24'h0, Validos}, 32'h01);
    chequear("bad_dig_kept", {28'h0, Digitos[11:8]}, 32'h3);

    // dp toggling must not disturb the stability count.
    for (int i = 1; i <= 4; i++) begin
      ciclo(8'hF7, (i % 2 == 1) ? 8'h99 : 8'h98);
      chequear("dp_nuevo", {31'h0, Nuevo}, {31'h0, (i == 4)});
    end
    chequear("dp_dig3", {28'h0, Digitos[15:12]}, 32'h4);
    chequear("dp_validos", {24'h0, Validos}, 32'h09);

    // Full scan F..8 across all eight digits.
    pulsos = 0;
    for (int d = 0; d < 8; d++) begin
      for (int i = 0; i < 5; i++) begin
        ciclo(scan_an[d], scan_seg[d]);
        if (Nuevo) pulsos++;
      end
    end
    chequear("scan_digitos", Digitos, 32'h89ABCDEF);
    chequear("scan_validos", {24'h0, Validos}, 32'hFF);
    chequear("scan_pulsos", pulsos, 32'd8);

    // Two anodes low: never qualifies.
    pulsos = 0;
    for (int i = 0; i < 6; i++) begin
      ciclo(8'hFC, 8'h03);
      if (Nuevo || Error) pulsos++;
    end
    chequear("multi_an_pulsos", pulsos, 32'd0);
    chequear("multi_an_digitos", Digitos, 32'h89ABCDEF);

    // Reset lands on what would have been the capturing edge.
    for (int i = 0; i < 3; i++) ciclo(8'hFE, 8'h03);
    reset = 1'b1;
    ciclo(8'hFE, 8'h03);
    chequear("rst_mid_nuevo", {31'h0, Nuevo}, 32'h0);
    chequear("rst_mid_validos", {24'h0, Validos}, 32'h0);
    chequear("rst_mid_digitos", Digitos, 32'h0);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ciclo(8'hFE, 8'h03);
      chequear("post_rst_nuevo", {31'h0, Nuevo}, {31'h0, (i == 4)});
    end
    chequear("post_rst_validos", {24'h0, Validos}, 32'h01);

    // Digit 0 shows "2" with dp lit.
    for (int i = 0; i < 4; i++) ciclo(8'hFE, 8'h24);
    chequear("dp_on_dig0", {28'h0, Digitos[3:0]}, 32'h2);
`ifdef DP_CAPTURE_EN
    chequear("puntos0", {31'h0, Puntos[0]}, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
    $finish;
  end

endmodule

// File: doc/display_lector.md
DISPLAY_LECTOR -- requirements
Module: display_lector

Interface
REQ-001 Parameter ESTABLE, default 4, meaning: consecutive cycles a pattern must hold before capture; legal range 1..255.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 AN  input  8  digit anodes, active-low; bit i low selects digit i.
REQ-005 Segmentos  input  8  segment bus, active-low; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
REQ-006 Digitos  output  32  decoded hex nibbles; digit i at bits [4i+3:4i].
REQ-007 Validos  output  8  bit i high = Digitos nibble i holds a valid decoded value.
REQ-008 Nuevo  output  1  one-cycle pulse on each successful capture.
REQ-009 Error  output  1  one-cycle pulse on each capture of an undecodable pattern.

Function
REQ-010 Qualifying input: AN has exactly one bit low; AN all-high or with more than one bit low SHALL be non-qualifying.
REQ-011 Pattern key SHALL be {AN, Segmentos[7:1]}; dp SHALL NOT affect stability or decoding.
REQ-012 States: IDLE (non-qualifying input), ESPERA (counting stability), CAPTURADO (captured, waiting for change).
REQ-013 IDLE -> ESPERA when input qualifies; counter loads 1.
REQ-014 ESPERA: key equal to previous cycle -> counter increments; key changed but qualifying -> counter reloads 1; non-qualifying -> IDLE, counter 0.
REQ-015 Counter reaching ESTABLE SHALL trigger capture and move to CAPTURADO in the same cycle.
REQ-016 Latency: pattern first present in cycle N, held stable -> Nuevo/Error asserted and Digitos/Validos updated in cycle N+ESTABLE.
REQ-017 CAPTURADO: unchanged key -> stay, no further capture; changed qualifying key -> ESPERA with counter 1; non-qualifying -> IDLE.
REQ-018 Decode table, Segmentos[7:1] compared against bits [7:1] of: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=19, A=11, B=C1, C=63, D=85, E=61, F=71 (hex).
REQ-019 Match on capture: write nibble into digit i, set Validos[i], pulse Nuevo; other digits untouched.
REQ-020 No match on capture: clear Validos[i], leave nibble i unchanged, pulse Error; Nuevo stays low.
REQ-021 Nuevo and Error SHALL never be high in the same cycle and SHALL be high for exactly one cycle per capture.
REQ-022 Counter SHALL saturate at ESTABLE; no wrap-around.

Reset
REQ-023 reset high at a rising edge: state IDLE, counter 0, Digitos 0, Validos 0, Nuevo 0, Error 0 (and Puntos 0 when compiled in).
REQ-024 reset SHALL override any capture in the same cycle; a count in progress SHALL be discarded.

Configuration
REQ-025 Macro DP_CAPTURE_EN defined: extra output Puntos (8 bits); on successful capture of digit i, Puntos[i] SHALL be set to NOT Segmentos[0]; Error captures leave Puntos unchanged.
REQ-026 DP_CAPTURE_EN undefined: no Puntos port, no dp storage; all other behaviour identical.

Verification
REQ-027 Reset: assert reset 2 cycles with any inputs -> Digitos=0, Validos=00, Nuevo=0, Error=0.
REQ-028 AN=FE, Segmentos=25 from cycle 0, held 10 cycles, ESTABLE=4 -> cycle 4: Nuevo=1, Digitos[3:0]=2, Validos=01; cycles 5-9: Nuevo=0.
REQ-029 AN=FD, Segmentos=61 held 3 cycles then AN=FF -> no Nuevo, Validos unchanged (glitch rejection).
REQ-030 AN=FB, Segmentos=FF held 6 cycles after valid capture of digit 2 -> Error pulse at cycle 4, Validos[2]=0, Digitos[11:8] unchanged.
REQ-031 Scan AN=FE..7F, Segmentos for F,E,D,C,B,A,9,8, 5 cycles each -> Digitos=89ABCDEF, Validos=FF, 8 Nuevo pulses; then AN=FC held -> no capture.
REQ-032 reset asserted at count 3 of a capture -> no Nuevo; with DP_CAPTURE_EN, AN=FE, Segmentos=24 -> Puntos[0]=1.
